cpu_call_stack: RTL

Parametrised return-address stack for the SM5xx CPU core. It replaces the fixed two-entry S/R register pair with a configurable depth and address width, so one core can target the SM510, SM511/SM512 and SM5a variants. The block adds an explicit overflow policy, occupancy flags, and a save-state read/write port. It sits between the instruction decoder (call/return strobes) and the PC register.

---
 rtl/cpu_call_stack.sv | 122 ++++++++++++
 1 files changed

// File: rtl/cpu_call_stack.sv
// Return-address stack for the SM5xx core: configurable depth, shift/hold overflow
// policy, occupancy flags and a save-state port for entry and count access.
module cpu_call_stack #(
   parameter  int ADDR_WIDTH    = 12,
   parameter  int DEPTH         = 2,
   parameter  int OVERFLOW_MODE = 0,
   localparam int CW            = $clog2(DEPTH + 1),
   localparam int IW            = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clear,
   input  logic                  push,
   input  logic [ADDR_WIDTH-1:0] push_addr,
   input  logic                  pop,
   output logic [ADDR_WIDTH-1:0] top,
   output logic [CW-1:0]         count,
   output logic                  empty,
   output logic                  full,
   output logic                  overflow,
   output logic                  underflow,
   input  logic [IW-1:0]         ss_index,
   output logic [ADDR_WIDTH-1:0] ss_rd_data,
   input  logic                  ss_wr,
   input  logic [ADDR_WIDTH-1:0] ss_wr_data,
   input  logic                  ss_count_wr,
   input  logic [CW-1:0]         ss_count_data
);

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [ADDR_WIDTH-1:0] entry_q [DEPTH];
   logic [ADDR_WIDTH-1:0] entry_d [DEPTH];
   logic [CW-1:0]         count_q;
   logic [CW-1:0]         count_d;
   logic                  overflow_d;
   logic                  underflow_d;
   logic                  is_empty;
   logic                  is_full;

   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == DEPTH_C);
   assign top      = entry_q[0];
   assign count    = count_q;
   assign empty    = is_empty;
   assign full     = is_full;

   // Indices at or beyond DEPTH read as zero (only reachable for non power-of-two depths).
   always_comb begin
      ss_rd_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ss_index == IW'(i)) begin
            ss_rd_data = entry_q[i];
         end
      end
   end

   always_comb begin
      entry_d     = entry_q;
      count_d     = count_q;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      if (clear) begin
         count_d = '0;
      end else if (push && pop) begin
         entry_d[0] = push_addr;
      end else if (push) begin
         if (is_full) begin
            overflow_d = 1'b1;
         end
         if (!is_full || (OVERFLOW_MODE == 0)) begin
            for (int i = 1; i < DEPTH; i++) begin
               entry_d[i] = entry_q[i-1];
            end
            entry_d[0] = push_addr;
         end
         if (!is_full) begin
            count_d = count_q + CW'(1);
         end
      end else if (pop) begin
         // Deepest entry keeps its value, so it duplicates upward as the stack drains.
         for (int i = 0; i < DEPTH - 1; i++) begin
            entry_d[i] = entry_q[i+1];
         end
         if (is_empty) begin
            underflow_d = 1'b1;
         end else begin
            count_d = count_q - CW'(1);
         end
      end else begin
         if (ss_wr) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (ss_index == IW'(i)) begin
                  entry_d[i] = ss_wr_data;
               end
            end
         end
         if (ss_count_wr) begin
            count_d = (ss_count_data > DEPTH_C) ? DEPTH_C : ss_count_data;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            entry_q[i] <= '0;
         end
         count_q   <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            entry_q[i] <= entry_d[i];
         end
         count_q   <= count_d;
         overflow  <= overflow_d;
         underflow <= underflow_d;
      end
   end

endmodule
